// File: rtl/usb_hub_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_hub_port_arbiter
// Purpose  : Round-robin, packet-locked arbiter for the hub upstream TX path,
//            with a grant watchdog and a fixed inter-packet gap.
// Revision : 1.0 - initial release
// ============================================================================
module usb_hub_port_arbiter #(
    parameter int NUM_USB_DEVICES = 16,
    parameter int IDX_W           = $clog2(NUM_USB_DEVICES),
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                       hi_clock,
    input  logic                       reset_n,
    input  logic [NUM_USB_DEVICES-1:0] port_enable,
    input  logic [NUM_USB_DEVICES-1:0] port_req,
    input  logic [NUM_USB_DEVICES-1:0] port_eop,
    input  logic                       host_busy,
    output logic [NUM_USB_DEVICES-1:0] grant,
    output logic                       grant_valid,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       timeout_err
);

    localparam int N     = NUM_USB_DEVICES;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [N-1:0]     w_eligible;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_eop_cur;
    logic             w_en_cur;
    logic             w_tmo_hit;
    logic             w_can_arb;

    assign w_eligible = port_req & port_enable;
    assign w_eop_cur  = port_eop[idx_q];
    assign w_en_cur   = port_enable[idx_q];
    assign w_tmo_hit  = (tmo_q == TMO_LAST);

    // First eligible port strictly after the last winner, wrapping; the last
    // winner itself is considered only at the very end of the sweep.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && w_eligible[(int'(rr_q) + k) % N]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(rr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        rr_d      = rr_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        w_can_arb = 1'b0;

        case (state_q)
            S_IDLE: w_can_arb = 1'b1;
            S_GRANT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (w_eop_cur || !w_en_cur || w_tmo_hit) begin
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    tmo_d   = '0;
                    gap_d   = '0;
                    err_d   = w_tmo_hit && !w_eop_cur && w_en_cur;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                // The final gap cycle arbitrates so the next grant lands right after it.
                if (gap_q == GAP_LAST) begin
                    w_can_arb = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_can_arb && w_found && !host_busy) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << w_win;
            idx_d   = w_win;
            valid_d = 1'b1;
            rr_d    = w_win;
            tmo_d   = '0;
            state_d = S_GRANT;
        end
    end

    always_ff @(posedge hi_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rr_q    <= IDX_W'(N - 1);
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_hub_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_hub_port_arbiter
// Purpose  : Scenario tasks plus randomized traffic against a behavioural arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_hub_port_arbiter;

    localparam int N    = 16;
    localparam int TMO  = 16;
    localparam int GAP  = 2;
    localparam int GMIN = (GAP > 0) ? GAP : 1;

    logic          hi_clock = 1'b0;
    logic          reset_n  = 1'b0;
    logic [N-1:0]  port_enable = '1;
    logic [N-1:0]  port_req    = '0;
    logic [N-1:0]  port_eop    = '0;
    logic          host_busy   = 1'b0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [3:0]    grant_idx;
    logic          timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model state: owning port (-1 = none), cycles held, idle cycles since release.
    int   m_owner;
    int   m_held;
    int   m_idle;
    int   m_last;
    logic m_err;

    usb_hub_port_arbiter #(
        .NUM_USB_DEVICES (N),
        .TIMEOUT_CYCLES  (TMO),
        .GAP_CYCLES      (GAP)
    ) dut (
        .hi_clock    (hi_clock),
        .reset_n     (reset_n),
        .port_enable (port_enable),
        .port_req    (port_req),
        .port_eop    (port_eop),
        .host_busy   (host_busy),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    always #5 hi_clock = ~hi_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_idle  = 1000;
        m_last  = N - 1;
        m_err   = 1'b0;
    endtask

    task automatic model_release(input logic by_timeout);
        m_owner = -1;
        m_held  = 0;
        m_idle  = 0;
        m_err   = by_timeout;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        m_err = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (port_eop[m_owner] || !port_enable[m_owner]) model_release(1'b0);
            else if (m_held == TMO) model_release(1'b1);
        end else begin
            if (m_idle < 1000) m_idle++;
            elig = port_req & port_enable;
            if (m_idle >= GMIN && !host_busy && elig != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && elig[(m_last + k) % N]) m_owner = (m_last + k) % N;
                end
                m_last = m_owner;
                m_held = 0;
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [N-1:0] eg;
        logic [3:0]   ei;
        @(posedge hi_clock);
        cyc++;
        if (!reset_n) model_reset();
        else model_step();
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ei = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        vectors++;
        if (grant !== eg || grant_valid !== (m_owner >= 0) || grant_idx !== ei || timeout_err !== m_err) begin
            miscompares++;
            $display("FAIL model cyc=%0d: got grant=%h valid=%b idx=%0d err=%b, want grant=%h valid=%b idx=%0d err=%b",
                     cyc, grant, grant_valid, grant_idx, timeout_err, eg, (m_owner >= 0), ei, m_err);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        port_req    = '0;
        port_eop    = '0;
        port_enable = '1;
        host_busy   = 1'b0;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_idx !== 4'd0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got grant=%h valid=%b idx=%0d err=%b, want all zero",
                     grant, grant_valid, grant_idx, timeout_err);
        end
    endtask

    task automatic test_first_grant();
        do_reset();
        port_req = 16'h0008;
        step();
        vectors++;
        if (grant !== 16'h0008 || grant_idx !== 4'd3 || grant_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_grant: got grant=%h idx=%0d valid=%b, want 0008/3/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 5, 9, 0, 5};
        int order[$];
        int gaps[$];
        int held = 0;
        int idle = 0;
        do_reset();
        port_req = 16'h0221;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            step();
            port_eop = '0;
            if (grant_valid) begin
                if (held == 0) begin
                    order.push_back(int'(grant_idx));
                    if (order.size() > 1) gaps.push_back(idle);
                end
                held++;
                if (held == 4) port_eop = grant;
            end else begin
                if (held != 0) begin
                    held = 0;
                    idle = 0;
                end
                idle++;
            end
        end
        port_eop = '0;
        vectors++;
        if (order.size() != 5) begin
            miscompares++;
            $display("FAIL rr_budget: got %0d grants, want 5 within 200 cycles", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (order[i] != exp_order[i]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got port %0d, want %0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (gaps[i] != GAP) begin
                    miscompares++;
                    $display("FAIL rr_gap[%0d]: got %0d idle cycles, want %0d", i, gaps[i], GAP);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        port_req = 16'h0084;
        step();
        vectors++;
        if (grant !== 16'h0004) begin
            miscompares++;
            $display("FAIL tmo_grant: got %h, want 0004", grant);
        end
        for (int i = 2; i <= TMO; i++) begin
            step();
            vectors++;
            if (grant !== 16'h0004 || timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL tmo_hold[%0d]: got grant=%h err=%b, want 0004/0", i, grant, timeout_err);
            end
        end
        step();
        vectors++;
        if (grant !== '0 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_pulse: got grant=%h err=%b, want 0000/1", grant, timeout_err);
        end
        step();
        vectors++;
        if (grant !== '0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_gap: got grant=%h err=%b, want 0000/0", grant, timeout_err);
        end
        step();
        vectors++;
        if (grant !== 16'h0080) begin
            miscompares++;
            $display("FAIL tmo_next: got grant=%h, want 0080", grant);
        end
    endtask

    task automatic test_host_busy();
        do_reset();
        host_busy = 1'b1;
        port_req  = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (grant !== '0) begin
                miscompares++;
                $display("FAIL busy_hold[%0d]: got grant=%h, want 0000", i, grant);
            end
        end
        host_busy = 1'b0;
        step();
        vectors++;
        if (grant !== 16'h0010) begin
            miscompares++;
            $display("FAIL busy_release: got grant=%h, want 0010", grant);
        end
    endtask

    task automatic test_enable();
        do_reset();
        port_enable = 16'hFFEF;
        port_req    = 16'h0011;
        step();
        vectors++;
        if (grant !== 16'h0001) begin
            miscompares++;
            $display("FAIL en_grant: got grant=%h, want 0001", grant);
        end
        step();
        step();
        port_enable = 16'hFFEE;
        step();
        vectors++;
        if (grant !== '0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL en_abort: got grant=%h err=%b, want 0000/0", grant, timeout_err);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (grant !== '0) begin
                miscompares++;
                $display("FAIL en_excluded[%0d]: got grant=%h, want 0000", i, grant);
            end
        end
    endtask

    task automatic test_coincide();
        do_reset();
        port_req = 16'h0002;
        step();
        for (int i = 2; i <= TMO; i++) step();
        port_eop = 16'h0002;
        step();
        port_eop = '0;
        vectors++;
        if (grant !== '0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL eop_vs_tmo: got grant=%h err=%b, want 0000/0", grant, timeout_err);
        end
        step();
        step();
        vectors++;
        if (grant !== 16'h0002) begin
            miscompares++;
            $display("FAIL regrant: got grant=%h, want 0002", grant);
        end
        for (int i = 2; i <= TMO; i++) step();
        port_enable = 16'hFFFD;
        step();
        port_enable = '1;
        vectors++;
        if (grant !== '0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_vs_tmo: got grant=%h err=%b, want 0000/0", grant, timeout_err);
        end
        // Async reset mid-grant, with a request pattern that would favour port 1 if rr were kept.
        do_reset();
        port_req = 16'h0003;
        step();
        step();
        reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_idx !== 4'd0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got grant=%h valid=%b idx=%0d err=%b, want zeros",
                     grant, grant_valid, grant_idx, timeout_err);
        end
        step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (grant !== 16'h0001) begin
            miscompares++;
            $display("FAIL post_reset_prio: got grant=%h, want 0001", grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            port_req    = 16'($urandom) | 16'($urandom);
            port_enable = ($urandom_range(0, 7) == 0) ? ~(16'h1 << $urandom_range(0, 15)) : 16'hFFFF;
            host_busy   = ($urandom_range(0, 3) == 0);
            port_eop    = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 9) == 0) port_eop = port_eop | grant;
            else port_eop = port_eop & ~grant;
            step();
        end
        port_eop = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_grant();
        test_round_robin();
        test_timeout();
        test_host_busy();
        test_enable();
        test_coincide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
